// File: rtl/data_sram_ctrl_pkg.sv
// Shared definitions for the SRAM data-port controller and its ROM twin.
package data_sram_ctrl_pkg;

  localparam int REG_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } sram_state_e;

  // SRAM strobes are active low; CPU write-enable is active high.
  localparam logic CHIP_ENABLE   = 1'b0;
  localparam logic CHIP_DISABLE  = 1'b1;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

endpackage

// File: rtl/data_sram_ctrl.sv
// Converts single-cycle CPU load/store requests into timed accesses on an
// asynchronous 32-bit SRAM, stalling the CPU until each access completes.
module data_sram_ctrl
  import data_sram_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        ram_ce_i,
  input  logic              ram_we_i,
  input  logic [31:0]       ram_addr_i,
  input  logic [3:0]        ram_sel_i,
  input  logic [REG_W-1:0]  ram_data_i,
  output logic [REG_W-1:0]  ram_data_o,
  output logic              stall_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [REG_W-1:0]  sram_data_o,
  output logic              sram_data_oe,
  input  logic [REG_W-1:0]  sram_data_i,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [3:0]        sram_be_n
);

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  sram_state_e       state_q, state_d;
  logic [3:0]        count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [REG_W-1:0]  wdata_q, wdata_d;
  logic [REG_W-1:0]  rdata_q, rdata_d;
  logic              data_oe_q, data_oe_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic [3:0]        be_n_q, be_n_d;
  logic              req;

  // Byte offset and bits above the SRAM window are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ram_addr_i[31:ADDR_W+2], ram_addr_i[1:0]};

  assign req     = |ram_ce_i;
  assign stall_o = req & (state_q != DONE);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    data_oe_d = data_oe_q;
    ce_n_d    = ce_n_q;
    oe_n_d    = oe_n_q;
    we_n_d    = we_n_q;
    be_n_d    = be_n_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = ram_addr_i[ADDR_W+1:2];
          be_n_d  = ~ram_sel_i;
          wdata_d = ram_data_i;
          ce_n_d  = CHIP_ENABLE;
          count_d = CNT_INIT;
          if (ram_we_i == WRITE_ENABLE) begin
            we_n_d    = 1'b0;
            data_oe_d = 1'b1;
          end else begin
            oe_n_d = 1'b0;
          end
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (count_q != 4'd0) begin
          count_d = count_q - 4'd1;
        end else begin
          // Loads are identified by the latched strobe, not by ram_we_i.
          if (!oe_n_q) rdata_d = sram_data_i;
          ce_n_d  = CHIP_DISABLE;
          oe_n_d  = 1'b1;
          we_n_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        data_oe_d = 1'b0;
        be_n_d    = 4'hF;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= 4'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      data_oe_q <= 1'b0;
      ce_n_q    <= CHIP_DISABLE;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      be_n_q    <= 4'hF;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      data_oe_q <= data_oe_d;
      ce_n_q    <= ce_n_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
      be_n_q    <= be_n_d;
    end
  end

  assign ram_data_o   = rdata_q;
  assign sram_addr_o  = addr_q;
  assign sram_data_o  = wdata_q;
  assign sram_data_oe = data_oe_q;
  assign sram_ce_n    = ce_n_q;
  assign sram_oe_n    = oe_n_q;
  assign sram_we_n    = we_n_q;
  assign sram_be_n    = be_n_q;

endmodule

// File: tb/tb_data_sram_ctrl.sv
// Self-checking bench for data_sram_ctrl: constant vector table, corner
// sequences, and random traffic against a word-array reference memory.
module tb_data_sram_ctrl;

  localparam int ADDR_W = 20;
  localparam int WC     = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  ram_ce_i = 4'h0;
  logic        ram_we_i = 1'b0;
  logic [31:0] ram_addr_i = 32'h0;
  logic [3:0]  ram_sel_i = 4'h0;
  logic [31:0] ram_data_i = 32'h0;
  logic [31:0] ram_data_o;
  logic        stall_o;
  logic [ADDR_W-1:0] sram_addr_o;
  logic [31:0] sram_data_o;
  logic        sram_data_oe;
  logic [31:0] sram_data_i;
  logic        sram_ce_n, sram_oe_n, sram_we_n;
  logic [3:0]  sram_be_n;

  data_sram_ctrl #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst(rst),
    .ram_ce_i(ram_ce_i), .ram_we_i(ram_we_i), .ram_addr_i(ram_addr_i),
    .ram_sel_i(ram_sel_i), .ram_data_i(ram_data_i), .ram_data_o(ram_data_o),
    .stall_o(stall_o), .sram_addr_o(sram_addr_o), .sram_data_o(sram_data_o),
    .sram_data_oe(sram_data_oe), .sram_data_i(sram_data_i),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_be_n(sram_be_n)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM model: writes lanes while CE/WE are low, reads when CE/OE low.
  logic [31:0] mem [0:1023];
  logic        loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      mem[4] <= 32'h12345678;
      loaded <= 1'b1;
    end else if (!sram_ce_n && !sram_we_n) begin
      for (int b = 0; b < 4; b++)
        if (!sram_be_n[b]) mem[sram_addr_o[9:0]][8*b +: 8] <= sram_data_o[8*b +: 8];
    end
  end
  assign sram_data_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr_o[9:0]] : 32'h0BADF00D;

  int we_low = 0, oe_low = 0, doe_cnt = 0, overlap = 0, oe_conflict = 0;
  always @(negedge clk) begin
    if (!sram_we_n) we_low <= we_low + 1;
    if (!sram_oe_n) oe_low <= oe_low + 1;
    if (sram_data_oe) doe_cnt <= doe_cnt + 1;
    if (!sram_we_n && !sram_oe_n) overlap <= overlap + 1;
    if (!sram_oe_n && sram_data_oe) oe_conflict <= oe_conflict + 1;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h", nm, act, exp);
    end
  endtask

  // Reference memory: plain word array keyed by the aliased word address.
  logic [31:0] ref_mem [0:1023];
  function automatic logic [9:0] word_of(input logic [31:0] a);
    return a[11:2];
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [3:0] sel, input logic [31:0] d);
    for (int b = 0; b < 4; b++)
      if (sel[b]) ref_mem[word_of(a)][8*b +: 8] = d[8*b +: 8];
  endtask

  // Runs one access starting just after a rising edge; returns observations.
  task automatic run_acc(input bit we, input logic [31:0] addr, input logic [3:0] sel,
                         input logic [31:0] wd, input bit gap,
                         output logic [31:0] rd, output int stalls,
                         output logic [31:0] a_seen, output logic [31:0] be_seen,
                         output int wl, output int ol, output int dl);
    int w0, o0, d0;
    bit done;
    w0 = we_low; o0 = oe_low; d0 = doe_cnt;
    ram_ce_i = 4'hF; ram_we_i = we; ram_addr_i = addr; ram_sel_i = sel; ram_data_i = wd;
    stalls = 0; done = 0; rd = 32'h0; a_seen = 32'h0; be_seen = 32'h0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (c == 1) begin a_seen = 32'(sram_addr_o); be_seen = 32'(sram_be_n); end
      if (stall_o) stalls++;
      else begin done = 1; rd = ram_data_o; end
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL access_timeout: got stall stuck want release");
    end
    @(posedge clk); #1;
    if (gap) begin
      ram_ce_i = 4'h0;
      @(negedge clk);
      chk("idle_stall", 32'(stall_o), 32'h0);
      @(posedge clk); #1;
    end
    wl = we_low - w0; ol = oe_low - o0; dl = doe_cnt - d0;
  endtask

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic [31:0] exp_a;
    logic [31:0] exp_be;
  } vec_t;

  vec_t tbl [9];

  initial begin
    logic [31:0] rd, a_s, be_s;
    int st, wl, ol, dl;

    tbl[0] = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         32'h12345678, 32'h4, 32'h0};
    tbl[1] = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEADBEEF,  32'h0,        32'h4, 32'h0};
    tbl[2] = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         32'hDEADBEEF, 32'h4, 32'h0};
    tbl[3] = '{1'b1, 32'h0000_0013, 4'h4, 32'h00AB0000,  32'h0,        32'h4, 32'hB};
    tbl[4] = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         32'hDEABBEEF, 32'h4, 32'h0};
    tbl[5] = '{1'b1, 32'h0040_0010, 4'hF, 32'hCAFEF00D,  32'h0,        32'h4, 32'h0};
    tbl[6] = '{1'b0, 32'h0080_0012, 4'h3, 32'h0,         32'hCAFEF00D, 32'h4, 32'hC};
    tbl[7] = '{1'b1, 32'h0000_0010, 4'h0, 32'hFFFFFFFF,  32'h0,        32'h4, 32'hF};
    tbl[8] = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         32'hCAFEF00D, 32'h4, 32'h0};
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
    ref_mem[4] = 32'h12345678;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ce_n", 32'(sram_ce_n), 32'h1);
    chk("rst_oe_n", 32'(sram_oe_n), 32'h1);
    chk("rst_we_n", 32'(sram_we_n), 32'h1);
    chk("rst_be_n", 32'(sram_be_n), 32'hF);
    chk("rst_data_oe", 32'(sram_data_oe), 32'h0);
    chk("rst_stall", 32'(stall_o), 32'h0);
    chk("rst_addr", 32'(sram_addr_o), 32'h0);
    chk("rst_rdata", ram_data_o, 32'h0);
    @(posedge clk); #1;

    // Vector table
    for (int i = 0; i < 9; i++) begin
      run_acc(tbl[i].we, tbl[i].addr, tbl[i].sel, tbl[i].wd, 1'b1, rd, st, a_s, be_s, wl, ol, dl);
      chk($sformatf("v%0d_stall", i), 32'(st), 32'(WC + 1));
      chk($sformatf("v%0d_addr", i), a_s, tbl[i].exp_a);
      chk($sformatf("v%0d_be_n", i), be_s, tbl[i].exp_be);
      chk($sformatf("v%0d_we_low", i), 32'(wl), tbl[i].we ? 32'(WC) : 32'h0);
      chk($sformatf("v%0d_oe_low", i), 32'(ol), tbl[i].we ? 32'h0 : 32'(WC));
      chk($sformatf("v%0d_data_oe", i), 32'(dl), tbl[i].we ? 32'(WC + 1) : 32'h0);
      if (tbl[i].we) ref_store(tbl[i].addr, tbl[i].sel, tbl[i].wd);
      else chk($sformatf("v%0d_rdata", i), rd, tbl[i].exp_rd);
    end

    // Back-to-back load then store: 4 cycles each, no strobe overlap
    run_acc(1'b0, 32'h0000_0010, 4'hF, 32'h0, 1'b0, rd, st, a_s, be_s, wl, ol, dl);
    chk("b2b_load_cycles", 32'(st + 1), 32'(WC + 2));
    chk("b2b_load_data_oe", 32'(dl), 32'h0);
    chk("b2b_load_rdata", rd, ref_mem[4]);
    run_acc(1'b1, 32'h0000_0014, 4'hF, 32'h55AA33CC, 1'b1, rd, st, a_s, be_s, wl, ol, dl);
    ref_store(32'h0000_0014, 4'hF, 32'h55AA33CC);
    chk("b2b_store_cycles", 32'(st + 1), 32'(WC + 2));
    chk("b2b_store_addr", a_s, 32'h5);
    chk("overlap_oe_we", 32'(overlap), 32'h0);
    chk("oe_with_data_oe", 32'(oe_conflict), 32'h0);

    // Asynchronous reset in the middle of a store
    ram_ce_i = 4'hF; ram_we_i = 1'b1; ram_addr_i = 32'h0000_0400;
    ram_sel_i = 4'hF; ram_data_i = 32'h11112222;
    @(posedge clk); #1;
    chk("midrst_we_before", 32'(sram_we_n), 32'h0);
    rst = 1'b1; #1;
    chk("midrst_we_n", 32'(sram_we_n), 32'h1);
    chk("midrst_ce_n", 32'(sram_ce_n), 32'h1);
    chk("midrst_data_oe", 32'(sram_data_oe), 32'h0);
    ram_ce_i = 4'h0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_stall", 32'(stall_o), 32'h0);
    @(posedge clk); #1;

    // Random traffic against the reference memory (words 0..7, aliased addresses)
    for (int k = 0; k < 40; k++) begin
      logic [31:0] a;
      bit w;
      logic [3:0] s;
      logic [31:0] d;
      a = $urandom;
      a[21:2] = 20'($urandom_range(0, 7));
      w = 1'($urandom_range(0, 1));
      s = 4'($urandom);
      d = $urandom;
      run_acc(w, a, s, d, 1'($urandom_range(0, 1)), rd, st, a_s, be_s, wl, ol, dl);
      chk($sformatf("r%0d_stall", k), 32'(st), 32'(WC + 1));
      chk($sformatf("r%0d_addr", k), a_s, 32'(a[21:2]));
      if (w) ref_store(a, s, d);
      else chk($sformatf("r%0d_rdata", k), rd, ref_mem[word_of(a)]);
    end
    chk("final_overlap", 32'(overlap), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang want finish");
    $fatal(1, "timeout");
  end

endmodule
